// File: rtl/dspb_serum_mem_stream_reader.sv
// Avalon-MM block reader for the on-chip RAM: fetches a contiguous word block
// and replays it as a framed Avalon-ST stream through a small output FIFO.
module dspb_serum_mem_stream_reader #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [ADDR_W:0]       length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,
    output logic [DATA_W-1:0]     src_data,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic                  src_sop,
    output logic                  src_eop
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   ONE_C     = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]   ZERO_C    = (ADDR_W + 1)'(0);
    localparam logic [PTR_W-1:0]  PTR_ONE_C = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE_C = CNT_W'(1);

    logic [1:0]          state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic [ADDR_W:0]     recv_q, recv_d;
    logic [ADDR_W:0]     acc_q, acc_d;
    logic                inflight_q;
    logic                done_q, done_d;

    // Each FIFO entry carries {eop, sop, data} so framing travels with the word.
    logic [DATA_W+1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                flush_s, issue_s, push_s, pop_s, last_pop_s;
    logic                sop_w_s, eop_w_s;
    logic [CNT_W:0]      occ_s;
    logic [DATA_W+1:0]   head_s;

    assign flush_s    = abort && (state_q != ST_IDLE);
    // Words already buffered plus the read whose data lands this cycle.
    assign occ_s      = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign issue_s    = (state_q == ST_RUN) && (issued_q < len_q) && (occ_s < DEPTH_C);
    assign push_s     = inflight_q && !flush_s;
    assign pop_s      = src_valid && src_ready;
    assign last_pop_s = pop_s && (acc_q == (len_q - ONE_C));
    assign sop_w_s    = (recv_q == ZERO_C);
    assign eop_w_s    = (recv_q == (len_q - ONE_C));

    assign mem_address    = base_q + issued_q[ADDR_W-1:0];
    assign mem_chipselect = issue_s;
    assign mem_write      = 1'b0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;

    assign head_s    = fifo_mem_q[rd_ptr_q];
    assign src_valid = (count_q != '0);
    assign src_data  = head_s[DATA_W-1:0];
    assign src_sop   = src_valid && head_s[DATA_W];
    assign src_eop   = src_valid && head_s[DATA_W+1];

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;

    // Transfer sequencing and block counters.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        recv_d   = recv_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        if (flush_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start && (length != ZERO_C)) begin
                        state_d  = ST_RUN;
                        base_d   = base_addr;
                        len_d    = length;
                        issued_d = ZERO_C;
                        recv_d   = ZERO_C;
                        acc_d    = ZERO_C;
                    end else if (start) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (issue_s && (issued_q == (len_q - ONE_C))) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_DRAIN: state_d = ST_DRAIN;
                default:  state_d = ST_IDLE;
            endcase
            if (issue_s) begin
                issued_d = issued_q + ONE_C;
            end else begin
                issued_d = issued_d;
            end
            if (push_s) begin
                recv_d = recv_q + ONE_C;
            end else begin
                recv_d = recv_d;
            end
            if (pop_s) begin
                acc_d = acc_q + ONE_C;
            end else begin
                acc_d = acc_d;
            end
            if (last_pop_s) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                done_d = done_d;
            end
        end
    end

    // Occupancy bookkeeping for the output FIFO.
    always_comb begin
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            recv_q     <= '0;
            acc_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            recv_q     <= recv_d;
            acc_q      <= acc_d;
            inflight_q <= issue_s && !flush_s;
            done_q     <= done_d;
        end
    end

    // FIFO pointers; abort flushes everything buffered.
    always_ff @(posedge clk) begin
        if (reset || flush_s) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE_C;
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE_C;
            end else begin
                rd_ptr_q <= rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // FIFO storage; contents are qualified by count so they need no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_q[wr_ptr_q] <= {eop_w_s, sop_w_s, mem_readdata};
        end
    end

endmodule

// File: tb/tb_dspb_serum_mem_stream_reader.sv
// Scoreboard bench for the RAM stream reader: a RAM model answers reads,
// expected beats and addresses are queued at start and checked by a monitor.
module tb_dspb_serum_mem_stream_reader;

    logic        clk = 1'b0;
    logic        reset, start, abort, src_ready;
    logic [15:0] base_addr;
    logic [16:0] length;
    logic        busy, done, mem_chipselect, mem_write, mem_clken;
    logic [15:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata, src_data;
    logic        src_valid, src_sop, src_eop;

    logic [31:0] ram [0:65535];
    logic [33:0] exp_q [$];
    logic [15:0] addr_q [$];

    int  tests = 0, fails = 0, cyc = 0;
    int  cs_total = 0, pop_total = 0, cs_base = 0, pop_base = 0;
    int  max_occ = 0, pops_in_test = 0, first_pop_cyc = 0, last_pop_cyc = 0;
    bit  rand_mode = 1'b0;
    bit  stall_q = 1'b0;
    logic [34:0] hold_q;

    dspb_serum_mem_stream_reader dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .busy(busy), .done(done),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_byteenable(mem_byteenable),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .src_sop(src_sop), .src_eop(src_eop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_chipselect) mem_readdata <= ram[mem_address];
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: address order, beat scoreboard, stall stability, occupancy.
    always @(negedge clk) begin
        int occ;
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (mem_chipselect) begin
                cs_total++;
                if (addr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_read: got address %0h expected no read", mem_address);
                end else begin
                    chk("read_addr", mem_address, addr_q.pop_front());
                end
            end
            occ = (cs_total - cs_base) - (pop_total - pop_base);
            if (occ > max_occ) max_occ = occ;
            if (stall_q) chk("stall_stable", {src_valid, src_sop, src_eop, src_data}, hold_q);
            if (src_valid && src_ready) begin
                if (pops_in_test == 0) first_pop_cyc = cyc;
                last_pop_cyc = cyc;
                pop_total++;
                pops_in_test++;
                if (exp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", src_data);
                end else begin
                    chk("beat", {src_sop, src_eop, src_data}, exp_q.pop_front());
                end
            end
            stall_q = src_valid && !src_ready && !abort;
            hold_q  = {1'b1, src_sop, src_eop, src_data};
        end
    end

    // Random ready pattern for the backpressure test.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_mode) src_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_block(input logic [15:0] b, input int l);
        logic [15:0] a;
        for (int i = 0; i < l; i++) begin
            a = b + 16'(i);
            addr_q.push_back(a);
            exp_q.push_back({(i == 0), (i == l - 1), ram[a]});
        end
    endtask

    task automatic pulse_start(input logic [15:0] b, input logic [16:0] l);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int maxc);
        bit seen = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            @(posedge clk); #1;
            if (done) begin seen = 1'b1; break; end
        end
        chk({nm, "_done"}, seen, 1);
        if (seen) chk({nm, "_busy_low"}, busy, 0);
        chk({nm, "_all_beats"}, exp_q.size(), 0);
        chk({nm, "_all_reads"}, addr_q.size(), 0);
    endtask

    task automatic snap();
        cs_base = cs_total; pop_base = pop_total; max_occ = 0; pops_in_test = 0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; src_ready = 1'b1;
        base_addr = 16'h0000; length = 17'd0;
        for (int i = 0; i < 65536; i++) ram[i] = 32'(i);
        ram[16'h0010] = 32'hA5A5_0001;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", mem_chipselect, 0);
        chk("rst_valid", src_valid, 0);
        chk("rst_sop_eop", {src_sop, src_eop}, 0);
        chk("rst_addr", mem_address, 0);
        chk("const_ports", {mem_write, mem_byteenable, mem_clken}, 6'b0_1111_1);
        reset = 1'b0;

        // Single word: exact cycle timing.
        snap();
        push_block(16'h0010, 1);
        pulse_start(16'h0010, 17'd1);
        chk("single_cs_t1", {mem_chipselect, busy}, 2'b11);
        @(posedge clk); #1;
        chk("single_valid_t2", src_valid, 0);
        @(posedge clk); #1;
        chk("single_beat_t3", {src_valid, src_sop, src_eop, src_data}, {3'b111, 32'hA5A5_0001});
        @(posedge clk); #1;
        chk("single_done_t4", {done, busy}, 2'b10);
        @(posedge clk); #1;
        chk("single_done_pulse", done, 0);
        chk("single_cs_count", cs_total - cs_base, 1);

        // Streaming at full rate.
        snap();
        push_block(16'h0100, 16);
        pulse_start(16'h0100, 17'd16);
        wait_done("stream", 60);
        chk("stream_beats", pops_in_test, 16);
        chk("stream_back_to_back", last_pop_cyc - first_pop_cyc, 15);

        // Random backpressure.
        snap();
        rand_mode = 1'b1;
        push_block(16'h0400, 32);
        pulse_start(16'h0400, 17'd32);
        wait_done("bp", 600);
        rand_mode = 1'b0;
        @(posedge clk); #2;
        src_ready = 1'b1;
        chk("bp_beats", pops_in_test, 32);
        chk("bp_max_occupancy_le4", (max_occ <= 4), 1);

        // Address wrap.
        snap();
        push_block(16'hFFFE, 4);
        pulse_start(16'hFFFE, 17'd4);
        wait_done("wrap", 40);
        chk("wrap_beats", pops_in_test, 4);

        // Zero length.
        snap();
        pulse_start(16'h0020, 17'd0);
        chk("zero_done", {done, busy}, 2'b10);
        @(posedge clk); #1;
        chk("zero_done_pulse", done, 0);
        chk("zero_no_read", cs_total - cs_base, 0);

        // Start while busy is ignored.
        snap();
        push_block(16'h0200, 8);
        pulse_start(16'h0200, 17'd8);
        @(posedge clk); #1;
        pulse_start(16'h0300, 17'd3);
        wait_done("busy_start", 60);
        repeat (4) @(posedge clk);
        #1;
        chk("busy_start_idle", {busy, done}, 2'b00);
        chk("busy_start_reads", cs_total - cs_base, 8);

        // Abort after 5 accepted beats, then a fresh block.
        snap();
        push_block(16'h0500, 20);
        pulse_start(16'h0500, 17'd20);
        for (int k = 0; k < 100; k++) begin
            @(posedge clk); #1;
            if (pops_in_test >= 5) begin src_ready = 1'b0; break; end
        end
        chk("abort_pre_beats", pops_in_test, 5);
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_outputs", {src_valid, busy, done}, 3'b000);
        exp_q.delete(); addr_q.delete();
        @(posedge clk); #1;
        chk("abort_quiet", {done, mem_chipselect, src_valid}, 3'b000);
        snap();
        src_ready = 1'b1;
        push_block(16'h0600, 6);
        pulse_start(16'h0600, 17'd6);
        wait_done("after_abort", 40);
        chk("after_abort_beats", pops_in_test, 6);

        // Reset mid-transfer.
        src_ready = 1'b0;
        push_block(16'h0700, 20);
        pulse_start(16'h0700, 17'd20);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outputs", {busy, done, mem_chipselect, src_valid, src_sop, src_eop}, 6'b0);
        chk("midrst_addr", mem_address, 0);
        reset = 1'b0;
        exp_q.delete(); addr_q.delete();
        snap();
        src_ready = 1'b1;
        push_block(16'h0800, 3);
        pulse_start(16'h0800, 17'd3);
        wait_done("after_reset", 40);
        chk("after_reset_beats", pops_in_test, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
